// File: rtl/temp_bar_filter.sv
// temp_bar_filter: block-averages ADC temperature codes and drives an N_LED thermometer bar.
// Optional feature: define TEMP_BAR_HYST_EN to apply the HYST margin before the level moves.
module temp_bar_filter #(
  parameter int                     ADC_W    = 12,
  parameter int                     N_LED    = 8,
  parameter int                     N_THR    = 6,
  parameter logic [N_THR*ADC_W-1:0] THRESH   = {12'd3666, 12'd3643, 12'd3625,
                                                12'd3595, 12'd3576, 12'd3550},
  parameter int                     AVG_LOG2 = 2,
  parameter int                     HYST     = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [ADC_W-1:0]           adc_dout,
  input  logic                       adc_valid,
  output logic [N_LED-1:0]           led,
  output logic [$clog2(N_THR+1)-1:0] level,
  output logic                       upd
);

  localparam int LW = $clog2(N_THR + 1);
  localparam int AW = ADC_W + AVG_LOG2;
  localparam int CW = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;

  if (N_THR < 1 || N_THR > N_LED || HYST < 0) begin : g_bad_cfg
    $error("temp_bar_filter: N_THR must be 1..N_LED and HYST non-negative");
  end

  logic [AW-1:0]    acc_q, acc_d, sum_s;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [ADC_W-1:0] avg_q, avg_d;
  logic             avg_stb_q, avg_stb_d;
  logic             last_s;
  logic [LW-1:0]    raw_s;
  logic [LW-1:0]    level_q, level_d;
  logic [N_LED-1:0] led_q, led_d;
  logic             upd_q, upd_d;
`ifdef TEMP_BAR_HYST_EN
  logic [LW-1:0]    c_hi_s, c_lo_s;
  logic             primed_q, primed_d;
`endif

  // Accumulate one block; the closing sample goes straight into the average.
  always_comb begin
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    avg_d     = avg_q;
    avg_stb_d = 1'b0;
    sum_s     = acc_q + AW'(adc_dout);
    last_s    = (AVG_LOG2 == 0) ? 1'b1 : (cnt_q == {CW{1'b1}});
    if (adc_valid) begin
      if (last_s) begin
        acc_d     = {AW{1'b0}};
        cnt_d     = {CW{1'b0}};
        avg_d     = sum_s[AW-1 -: ADC_W];
        avg_stb_d = 1'b1;
      end else begin
        acc_d = sum_s;
        cnt_d = cnt_q + CW'(1);
      end
    end else begin
      avg_stb_d = 1'b0;
    end
  end

  // Threshold counts; the hysteresis bands are widened by one bit so THRESH+HYST cannot wrap.
  always_comb begin
    logic [ADC_W-1:0] thr_v;
`ifdef TEMP_BAR_HYST_EN
    logic [ADC_W:0]   thr_hi_v;
    logic [ADC_W-1:0] thr_lo_v;
    c_hi_s = {LW{1'b0}};
    c_lo_s = {LW{1'b0}};
`endif
    raw_s = {LW{1'b0}};
    for (int i = 0; i < N_THR; i++) begin
      thr_v = THRESH[i*ADC_W +: ADC_W];
      if (avg_q > thr_v) begin
        raw_s = raw_s + LW'(1);
      end else begin
        raw_s = raw_s;
      end
`ifdef TEMP_BAR_HYST_EN
      thr_hi_v = {1'b0, thr_v} + (ADC_W+1)'(HYST);
      thr_lo_v = (thr_v > ADC_W'(HYST)) ? (thr_v - ADC_W'(HYST)) : {ADC_W{1'b0}};
      if ({1'b0, avg_q} > thr_hi_v) begin
        c_hi_s = c_hi_s + LW'(1);
      end else begin
        c_hi_s = c_hi_s;
      end
      if (avg_q > thr_lo_v) begin
        c_lo_s = c_lo_s + LW'(1);
      end else begin
        c_lo_s = c_lo_s;
      end
`endif
    end
  end

  // Level/bar update, only on an averaged-sample strobe.
  always_comb begin
    level_d = level_q;
    led_d   = led_q;
    upd_d   = 1'b0;
`ifdef TEMP_BAR_HYST_EN
    primed_d = primed_q;
`endif
    if (avg_stb_q) begin
      upd_d = 1'b1;
`ifdef TEMP_BAR_HYST_EN
      primed_d = 1'b1;
      if (!primed_q) begin
        level_d = raw_s;
      end else if (c_hi_s > level_q) begin
        level_d = c_hi_s;
      end else if (c_lo_s < level_q) begin
        level_d = c_lo_s;
      end else begin
        level_d = level_q;
      end
`else
      level_d = raw_s;
`endif
      led_d = {N_LED{1'b1}} << level_d;
    end else begin
      upd_d = 1'b0;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q     <= {AW{1'b0}};
      cnt_q     <= {CW{1'b0}};
      avg_q     <= {ADC_W{1'b0}};
      avg_stb_q <= 1'b0;
      level_q   <= LW'(N_THR);
      led_q     <= {N_LED{1'b0}};
      upd_q     <= 1'b0;
`ifdef TEMP_BAR_HYST_EN
      primed_q  <= 1'b0;
`endif
    end else begin
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      avg_q     <= avg_d;
      avg_stb_q <= avg_stb_d;
      level_q   <= level_d;
      led_q     <= led_d;
      upd_q     <= upd_d;
`ifdef TEMP_BAR_HYST_EN
      primed_q  <= primed_d;
`endif
    end
  end

  assign led   = led_q;
  assign level = level_q;
  assign upd   = upd_q;

endmodule

// File: tb/tb_temp_bar_filter.sv
// Self-checking bench for temp_bar_filter: directed scenarios plus randomized blocks against a
// reference model that averages sample lists and counts thresholds with plain integer arithmetic.
`timescale 1ns/1ps
module tb_temp_bar_filter;

  localparam int N_THR = 6;
  localparam int HYST  = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        adc_valid = 1'b0;
  logic [11:0] adc_dout = 12'd0;
  logic [7:0]  led;
  logic [2:0]  level;
  logic        upd;

  temp_bar_filter dut (
    .clk(clk), .rst_n(rst_n), .adc_dout(adc_dout), .adc_valid(adc_valid),
    .led(led), .level(level), .upd(upd)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;
  int spur   = 0;

  // Observed upd events (cycle, led, level) and expected events from the model.
  int         ul_cyc[$];
  logic [7:0] ul_led[$];
  logic [2:0] ul_lvl[$];
  int         ex_cyc[$];
  logic [7:0] ex_led[$];
  logic [2:0] ex_lvl[$];
  logic [7:0] prev_led;
  logic [2:0] prev_lvl;

  always @(negedge clk) begin
    if (upd === 1'b1) begin
      ul_cyc.push_back(cyc);
      ul_led.push_back(led);
      ul_lvl.push_back(level);
    end
    if (rst_n === 1'b1 && upd !== 1'b1 && (led !== prev_led || level !== prev_lvl))
      spur <= spur + 1;
    prev_led <= led;
    prev_lvl <= level;
    cyc      <= cyc + 1;
  end

  // Reference model.
  int thr[N_THR] = '{3550, 3576, 3595, 3625, 3643, 3666};
  int m_samp[$];
  int m_level  = N_THR;
  bit m_primed = 1'b0;

  function automatic int n_above(input int a, input int off);
    int n = 0;
    int t;
    foreach (thr[i]) begin
      t = thr[i] + off;
      if (t < 0) t = 0;
      if (a > t) n++;
    end
    return n;
  endfunction

  function automatic logic [7:0] model_led(input int l);
    return 8'(255 - ((1 << l) - 1));
  endfunction

  task automatic model_eval(input int avg);
    int raw = n_above(avg, 0);
`ifdef TEMP_BAR_HYST_EN
    int chi = n_above(avg, HYST);
    int clo = n_above(avg, -HYST);
    if (!m_primed) m_level = raw;
    else if (chi > m_level) m_level = chi;
    else if (clo < m_level) m_level = clo;
`else
    m_level = raw;
`endif
    m_primed = 1'b1;
  endtask

  // Present one sample after 'gap' idle cycles; entry/exit point is 1ns after a rising edge.
  task automatic send(input int v, input int gap);
    adc_valid = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
    adc_valid = 1'b1;
    adc_dout  = 12'(v);
    m_samp.push_back(v);
    if (m_samp.size() == 4) begin
      int s = 0;
      foreach (m_samp[k]) s += m_samp[k];
      model_eval(s / 4);
      ex_cyc.push_back(cyc + 2);
      ex_led.push_back(model_led(m_level));
      ex_lvl.push_back(3'(m_level));
      m_samp.delete();
    end
    @(posedge clk); #1;
    adc_valid = 1'b0;
  endtask

  task automatic send_block(input int v);
    repeat (4) send(v, 0);
  endtask

  task automatic idle(input int n);
    adc_valid = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    idle(2);
    rst_n = 1'b1;
    m_samp.delete();
    m_level  = N_THR;
    m_primed = 1'b0;
  endtask

  task automatic test_reset();
    int b = ul_cyc.size();
    @(posedge clk); #1;
    for (int i = 0; i < 6; i++) begin
      adc_valid = i[0];
      adc_dout  = 12'd3500;
      @(posedge clk); #1;
      checks++;
      if (led !== 8'h00 || level !== 3'd6 || upd !== 1'b0) begin
        fails++;
        $display("FAIL reset_hold%0d: got led=%h level=%0d upd=%b, expected led=00 level=6 upd=0",
                 i, led, level, upd);
      end
    end
    adc_valid = 1'b0;
    rst_n = 1'b1;
    idle(4);
    checks++;
    if (ul_cyc.size() != b || led !== 8'h00 || level !== 3'd6) begin
      fails++;
      $display("FAIL reset_release: got %0d upd led=%h level=%0d, expected 0 upd led=00 level=6",
               ul_cyc.size() - b, led, level);
    end
  endtask

  task automatic test_basic();
    int b = ul_cyc.size();
    ex_cyc.delete(); ex_led.delete(); ex_lvl.delete();
    send_block(3500);
    idle(3);
    checks++;
    if (led !== 8'hFF || level !== 3'd0) begin
      fails++;
      $display("FAIL basic_hot: got led=%h level=%0d, expected led=ff level=0", led, level);
    end
    send_block(3700);
    idle(3);
    checks++;
    if (led !== 8'hC0 || level !== 3'd6) begin
      fails++;
      $display("FAIL basic_cold: got led=%h level=%0d, expected led=c0 level=6", led, level);
    end
    checks++;
    if (ul_cyc.size() - b != ex_cyc.size()) begin
      fails++;
      $display("FAIL basic_count: got %0d upd, expected %0d", ul_cyc.size() - b, ex_cyc.size());
    end else foreach (ex_cyc[k]) begin
      checks++;
      if (ul_cyc[b+k] != ex_cyc[k] || ul_led[b+k] !== ex_led[k] || ul_lvl[b+k] !== ex_lvl[k]) begin
        fails++;
        $display("FAIL basic_upd%0d: got cyc=%0d led=%h level=%0d, expected cyc=%0d led=%h level=%0d",
                 k, ul_cyc[b+k], ul_led[b+k], ul_lvl[b+k], ex_cyc[k], ex_led[k], ex_lvl[k]);
      end
    end
  endtask

  task automatic test_averaging();
    int b = ul_cyc.size();
    int s1[4] = '{3570, 3580, 3590, 3600};
    int s2[4] = '{3551, 3552, 3552, 3552};
    ex_cyc.delete(); ex_led.delete(); ex_lvl.delete();
    foreach (s1[i]) send(s1[i], 0);
    idle(3);
    checks++;
    if (led !== 8'hFC || level !== 3'd2) begin
      fails++;
      $display("FAIL avg_3585: got led=%h level=%0d, expected led=fc level=2", led, level);
    end
    foreach (s2[i]) send(s2[i], 0);
    idle(3);
    checks++;
    if (led !== 8'hFE || level !== 3'd1) begin
      fails++;
      $display("FAIL avg_trunc: got led=%h level=%0d, expected led=fe level=1", led, level);
    end
    checks++;
    if (ul_cyc.size() - b != ex_cyc.size()) begin
      fails++;
      $display("FAIL avg_count: got %0d upd, expected %0d", ul_cyc.size() - b, ex_cyc.size());
    end else foreach (ex_cyc[k]) begin
      checks++;
      if (ul_cyc[b+k] != ex_cyc[k] || ul_led[b+k] !== ex_led[k] || ul_lvl[b+k] !== ex_lvl[k]) begin
        fails++;
        $display("FAIL avg_upd%0d: got cyc=%0d led=%h level=%0d, expected cyc=%0d led=%h level=%0d",
                 k, ul_cyc[b+k], ul_led[b+k], ul_lvl[b+k], ex_cyc[k], ex_led[k], ex_lvl[k]);
      end
    end
  endtask

  task automatic test_hysteresis();
    int b = ul_cyc.size();
    logic [7:0] exp_near;
`ifdef TEMP_BAR_HYST_EN
    exp_near = 8'hFE;
`else
    exp_near = 8'hFC;
`endif
    ex_cyc.delete(); ex_led.delete(); ex_lvl.delete();
    send_block(3560);
    idle(3);
    checks++;
    if (led !== 8'hFE) begin
      fails++;
      $display("FAIL hyst_base: got led=%h, expected led=fe", led);
    end
    send_block(3578);
    idle(3);
    checks++;
    if (led !== exp_near) begin
      fails++;
      $display("FAIL hyst_near: got led=%h, expected led=%h", led, exp_near);
    end
    send_block(3581);
    idle(3);
    checks++;
    if (led !== 8'hFC) begin
      fails++;
      $display("FAIL hyst_cross: got led=%h, expected led=fc", led);
    end
    checks++;
    if (ul_cyc.size() - b != 3) begin
      fails++;
      $display("FAIL hyst_count: got %0d upd, expected 3", ul_cyc.size() - b);
    end else foreach (ex_cyc[k]) begin
      checks++;
      if (ul_cyc[b+k] != ex_cyc[k] || ul_led[b+k] !== ex_led[k] || ul_lvl[b+k] !== ex_lvl[k]) begin
        fails++;
        $display("FAIL hyst_upd%0d: got cyc=%0d led=%h level=%0d, expected cyc=%0d led=%h level=%0d",
                 k, ul_cyc[b+k], ul_led[b+k], ul_lvl[b+k], ex_cyc[k], ex_led[k], ex_lvl[k]);
      end
    end
  endtask

  task automatic test_reset_mid_block();
    int b;
    send(3500, 0);
    send(3500, 0);
    pulse_reset();
    checks++;
    if (led !== 8'h00 || level !== 3'd6) begin
      fails++;
      $display("FAIL rstmid_state: got led=%h level=%0d, expected led=00 level=6", led, level);
    end
    b = ul_cyc.size();
    ex_cyc.delete(); ex_led.delete(); ex_lvl.delete();
    send_block(3700);
    idle(4);
    checks++;
    if (ul_cyc.size() - b != 1 || led !== 8'hC0 || level !== 3'd6) begin
      fails++;
      $display("FAIL rstmid_discard: got %0d upd led=%h level=%0d, expected 1 upd led=c0 level=6",
               ul_cyc.size() - b, led, level);
    end
    pulse_reset();
    send_block(3664);
    idle(4);
    checks++;
    if (led !== 8'hE0 || level !== 3'd5) begin
      fails++;
      $display("FAIL rstmid_first_raw: got led=%h level=%0d, expected led=e0 level=5", led, level);
    end
  endtask

  task automatic test_gapped();
    int b  = ul_cyc.size();
    int s0 = spur;
    ex_cyc.delete(); ex_led.delete(); ex_lvl.delete();
    send(3620, 0);
    repeat (3) send(3620, $urandom_range(5, 0));
    idle(5);
    checks++;
    if (ul_cyc.size() - b != 1) begin
      fails++;
      $display("FAIL gap_count: got %0d upd, expected 1", ul_cyc.size() - b);
    end else begin
      checks++;
      if (ul_cyc[b] != ex_cyc[0] || ul_led[b] !== 8'hF8 || ul_lvl[b] !== 3'd3) begin
        fails++;
        $display("FAIL gap_upd: got cyc=%0d led=%h level=%0d, expected cyc=%0d led=f8 level=3",
                 ul_cyc[b], ul_led[b], ul_lvl[b], ex_cyc[0]);
      end
    end
    checks++;
    if (spur != s0) begin
      fails++;
      $display("FAIL gap_hold: got %0d led/level changes outside upd, expected 0", spur - s0);
    end
  endtask

  task automatic test_back_to_back();
    int b  = ul_cyc.size();
    int s0 = spur;
    ex_cyc.delete(); ex_led.delete(); ex_lvl.delete();
    for (int n = 0; n < 30; n++) begin
      int base = $urandom_range(3720, 3530);
      for (int j = 0; j < 4; j++)
        send(base + $urandom_range(12, 0) - 6, ($urandom_range(3, 0) == 0) ? 1 : 0);
    end
    idle(5);
    checks++;
    if (ul_cyc.size() - b != ex_cyc.size()) begin
      fails++;
      $display("FAIL b2b_count: got %0d upd, expected %0d", ul_cyc.size() - b, ex_cyc.size());
    end else foreach (ex_cyc[k]) begin
      checks++;
      if (ul_cyc[b+k] != ex_cyc[k] || ul_led[b+k] !== ex_led[k] || ul_lvl[b+k] !== ex_lvl[k]) begin
        fails++;
        $display("FAIL b2b_upd%0d: got cyc=%0d led=%h level=%0d, expected cyc=%0d led=%h level=%0d",
                 k, ul_cyc[b+k], ul_led[b+k], ul_lvl[b+k], ex_cyc[k], ex_led[k], ex_lvl[k]);
      end
    end
    checks++;
    if (spur != s0) begin
      fails++;
      $display("FAIL b2b_hold: got %0d led/level changes outside upd, expected 0", spur - s0);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_averaging();
    test_hysteresis();
    test_reset_mid_block();
    test_gapped();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
